score_ram_arbiter: RTL

SCORE_RAM_ARBITER -- requirements
Module: score_ram_arbiter

---
 rtl/score_ram_arb_pkg.sv | 12 +
 rtl/score_ram_arbiter_rr_pick.sv | 34 +++
 rtl/score_ram_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/score_ram_arb_pkg.sv
// Shared definitions for the score RAM arbiter: FSM state encodings and
// the default RAM geometry (32 slots of 14-bit scores).
package score_ram_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 14;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;

endpackage

// File: rtl/score_ram_arbiter_rr_pick.sv
// Winner selection between the two RAM requesters.
// With SCORE_ARB_ROUND_ROBIN_EN defined a tie goes to the requester that was
// not granted last; otherwise requester 0 always wins a tie.
module rr_pick
    import score_ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

`ifdef SCORE_ARB_ROUND_ROBIN_EN
    // A lone requester wins outright; a tie goes away from the last winner.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11)
            winner = ~last;
        else
            winner = req[1];
    end
`else
    // The pointer has no effect in fixed-priority mode.
    logic unused_last;
    assign unused_last = last;

    // Requester 0 wins whenever it is present.
    always_comb begin
        winner = 1'b0;
        if (!req[0])
            winner = req[1];
    end
`endif

endmodule

// File: rtl/score_ram_arbiter.sv
// Two-port arbiter in front of a single-port score RAM with one-cycle read
// latency. Each access is IDLE -> ACCESS (grant) -> [RDWAIT (read data)] -> IDLE,
// which guarantees at least one idle bus cycle between accesses.
// Tie-breaking mode is selected by the SCORE_ARB_ROUND_ROBIN_EN macro (see rr_pick).
module score_ram_arbiter
    import score_ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    logic [1:0] state;
    logic       last;     // most recent winner; also owner of the access in flight
    logic       winner;

    rr_pick u_pick (
        .req    ({req1, req0}),
        .last   (last),
        .winner (winner)
    );

    // The RAM registers its output, so in RDWAIT its data is already current.
    assign rdata = ram_rdata;
    assign busy  = (state != IDLE);

    // Access sequencing: latch the winner's command, grant, then deliver read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        last      <= winner;
                        gnt0      <= ~winner;
                        gnt1      <= winner;
                        ram_addr  <= winner ? addr1  : addr0;
                        ram_we    <= winner ? we1    : we0;
                        ram_wdata <= winner ? wdata1 : wdata0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    gnt0   <= 1'b0;
                    gnt1   <= 1'b0;
                    ram_we <= 1'b0;
                    if (ram_we) begin
                        state <= IDLE;
                    end else begin
                        rvalid0 <= ~last;
                        rvalid1 <= last;
                        state   <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
